// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: packs LE bytes into 32-bit words, writes them to
// instruction memory and holds the CPU in reset until the image is complete.
module imem_boot_loader #(
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter logic [31:0] MAX_WORDS = 32'd4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        IN_VALID,
    input  logic [7:0]  IN_DATA,
    output logic        IN_READY,
    output logic [63:0] MEM_WADDR,
    output logic [31:0] MEM_DATAIN,
    output logic        MEM_WR,
    output logic        CPU_HOLD,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_idx;
    logic [23:0] acc;
    logic [31:0] word_idx;
    logic [31:0] len;
    logic        accept;
    logic        last_byte;
    logic [31:0] word_in;

    assign accept    = IN_VALID & IN_READY;
    assign last_byte = accept && (byte_idx == 2'd3);
    // first three bytes sit in acc, the fourth completes the word in place
    assign word_in   = {IN_DATA, acc};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (START) state_nxt = S_HDR;
            S_HDR: begin
                if (last_byte) begin
                    if (word_in == 32'd0)           state_nxt = S_DONE;
                    else if (word_in > MAX_WORDS)   state_nxt = S_ERROR;
                    else                            state_nxt = S_DATA;
                end
            end
            S_DATA:  if (last_byte) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (word_idx + 32'd1 == len) ? S_DONE : S_DATA;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= S_IDLE;
            byte_idx   <= 2'd0;
            acc        <= 24'd0;
            word_idx   <= 32'd0;
            len        <= 32'd0;
            MEM_WADDR  <= BASE_ADDR;
            MEM_DATAIN <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (START) begin
                        byte_idx <= 2'd0;
                        word_idx <= 32'd0;
                    end
                end
                S_HDR, S_DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        acc      <= {IN_DATA, acc[23:8]};
                    end
                    if (last_byte && state == S_HDR)
                        len <= word_in;
                    if (last_byte && state == S_DATA) begin
                        MEM_DATAIN <= word_in;
                        MEM_WADDR  <= BASE_ADDR + {30'd0, word_idx, 2'b00};
                    end
                end
                S_WRITE: word_idx <= word_idx + 32'd1;
                default: ;
            endcase
        end
    end

    assign IN_READY = (state == S_HDR) || (state == S_DATA);
    assign MEM_WR   = (state == S_WRITE);
    assign DONE     = (state == S_DONE);
    assign ERR      = (state == S_ERROR);
    assign CPU_HOLD = (state != S_DONE);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader; expected writes come from a stream-level
// model that parses each image into (address, word) pairs.
module tb_imem_boot_loader;

    localparam logic [63:0] BASE = 64'h1000;
    localparam logic [31:0] MAXW = 32'd4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [7:0]  IN_DATA = 8'd0;
    logic        IN_READY, MEM_WR, CPU_HOLD, DONE, ERR;
    logic [63:0] MEM_WADDR;
    logic [31:0] MEM_DATAIN;

    imem_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
        .IN_READY(IN_READY), .MEM_WADDR(MEM_WADDR), .MEM_DATAIN(MEM_DATAIN),
        .MEM_WR(MEM_WR), .CPU_HOLD(CPU_HOLD), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // every write strobe must match the next word the model predicted
    always @(negedge CLK) begin
        if (MEM_WR !== 1'b0) begin
            chk("wr_ready_low", {63'd0, IN_READY}, 64'd0);
            if (exp_addr.size() == 0) chk("unexpected_wr", 64'd1, 64'd0);
            else begin
                chk("wr_addr", MEM_WADDR, exp_addr.pop_front());
                chk("wr_data", {32'd0, MEM_DATAIN}, {32'd0, exp_data.pop_front()});
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_ready", {63'd0, IN_READY}, 64'd0);
        chk("rst_wr",    {63'd0, MEM_WR},   64'd0);
        chk("rst_waddr", MEM_WADDR, BASE);
        chk("rst_data",  {32'd0, MEM_DATAIN}, 64'd0);
        chk("rst_hold",  {63'd0, CPU_HOLD}, 64'd1);
        chk("rst_done",  {63'd0, DONE}, 64'd0);
        chk("rst_err",   {63'd0, ERR},  64'd0);
    endtask

    task automatic do_reset(input int n);
        RST = 1'b0;
        repeat (n) begin
            IN_VALID = 1'($urandom);
            IN_DATA  = 8'($urandom);
            START    = 1'($urandom);
            @(negedge CLK);
        end
        chk_reset_vals();
        RST = 1'b1; START = 1'b0; IN_VALID = 1'b0;
    endtask

    task automatic idle_noise(input int n);
        repeat (n) begin
            IN_VALID = 1'($urandom);
            IN_DATA  = 8'($urandom);
            @(negedge CLK);
            chk("idle_ready", {63'd0, IN_READY}, 64'd0);
        end
        IN_VALID = 1'b0;
    endtask

    // offers one byte with a random lead-in gap; returns at the negedge after acceptance
    task automatic feed_byte(input logic [7:0] b, input int gap_max, output bit ok);
        bit acc = 0;
        repeat ($urandom_range(0, gap_max)) begin
            IN_VALID = 1'b0; IN_DATA = 8'($urandom);
            START = ($urandom_range(0, 7) == 0);
            @(negedge CLK);
        end
        IN_VALID = 1'b1; IN_DATA = b;
        for (int t = 0; t < 50 && !acc; t++) begin
            START = ($urandom_range(0, 7) == 0);
            acc = IN_READY;
            @(negedge CLK);
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        ok = acc;
    endtask

    task automatic make_image(input int len, output logic [7:0] q[$]);
        logic [31:0] l = 32'(len);
        q = {};
        for (int i = 0; i < 4; i++) q.push_back(l[8*i +: 8]);
        if (l <= MAXW)
            for (int i = 0; i < 4 * len; i++) q.push_back(8'($urandom));
    endtask

    task automatic send_image(input logic [7:0] b[$], input int gap_max);
        logic [31:0] len = {b[3], b[2], b[1], b[0]};
        bit ok = 1;
        if (len != 0 && len <= MAXW)
            for (int i = 0; i < int'(len); i++) begin
                exp_addr.push_back(BASE + 64'(4 * i));
                exp_data.push_back({b[4*i+7], b[4*i+6], b[4*i+5], b[4*i+4]});
            end
        START = 1'b1; @(negedge CLK); START = 1'b0;
        for (int i = 0; i < b.size() && ok; i++) begin
            feed_byte(b[i], gap_max, ok);
            if (ok && i >= 4 && (i % 4) == 3) chk("wr_latency", {63'd0, MEM_WR}, 64'd1);
        end
        IN_VALID = 1'b0; START = 1'b0;
        if (len == 0) begin
            chk("zero_done", {63'd0, DONE}, 64'd1);
            chk("zero_hold", {63'd0, CPU_HOLD}, 64'd0);
        end else if (len > MAXW) begin
            chk("err_flag",  {63'd0, ERR}, 64'd1);
            chk("err_hold",  {63'd0, CPU_HOLD}, 64'd1);
            chk("err_ready", {63'd0, IN_READY}, 64'd0);
            chk("err_done",  {63'd0, DONE}, 64'd0);
        end else begin
            @(negedge CLK);
            chk("img_done",  {63'd0, DONE}, 64'd1);
            chk("img_hold",  {63'd0, CPU_HOLD}, 64'd0);
            chk("img_err",   {63'd0, ERR}, 64'd0);
            chk("img_ready", {63'd0, IN_READY}, 64'd0);
        end
        chk("all_words_written", 64'(exp_addr.size()), 64'd0);
    endtask

    initial begin
        logic [7:0] img[$];
        bit ok;

        do_reset(2);

        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                8'h93, 8'h05, 8'h10, 8'h00};
        send_image(img, 0);
        idle_noise(4);

        img = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_image(img, 2);
        idle_noise(3);

        img = '{8'h05, 8'h00, 8'h00, 8'h00};
        send_image(img, 1);
        idle_noise(3);
        img = '{8'h00, 8'h00, 8'h00, 8'h01};
        send_image(img, 0);
        make_image(1, img);
        send_image(img, 2);

        make_image(4, img);
        send_image(img, 3);

        // reset after two bytes of the first data word
        make_image(2, img);
        START = 1'b1; @(negedge CLK); START = 1'b0;
        for (int i = 0; i < 6; i++) feed_byte(img[i], 1, ok);
        IN_VALID = 1'b0;
        do_reset(1);
        idle_noise(2);
        send_image(img, 1);

        for (int k = 0; k < 20; k++) begin
            make_image($urandom_range(0, 6), img);
            send_image(img, $urandom_range(0, 3));
            idle_noise($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
